// File: rtl/adc_spi_pkg.sv
// Shared constants and state type for the ADC SPI responder.
// Frame geometry: 16-bit frame, 4 leading zeros, channel address in DIN bits 13..11.
package adc_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int FRAME_LEN  = 16;
    localparam int LEAD_ZEROS = 4;
    localparam int ADDR_MSB   = 13;
    localparam int ADDR_LSB   = 11;
    localparam int ADDR_W     = ADDR_MSB - ADDR_LSB + 1;
    localparam int BIT_CNT_W  = 5;
    // Only DIN bits down to the address field need to be kept.
    localparam int RX_W       = ADDR_MSB;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer with rising/falling edge detection.
// Reset loads the idle level so no edge is reported on reset release.
module sync_edge_det #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_cur;

    assign w_cur  = r_sync[STAGES-1];
    assign o_rise = w_cur & ~r_prev;
    assign o_fall = ~w_cur & r_prev;

    // Synchronizer chain plus one-cycle history for edge detection
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{IDLE_VAL}};
            r_prev <= IDLE_VAL;
        end else begin
            r_sync <= STAGES'({r_sync, i_async});
            r_prev <= w_cur;
        end
    end

endmodule

// File: rtl/adc_spi_responder.sv
// Behavioural SPI responder modelling a multi-channel ADC.
// Optional ADC_AUTO_INC_EN: transmitted channel value increments per frame.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12
) (
    input  logic              CLK50MHZ,
    input  logic              RST_N,
    input  logic              ADC_CS_N_i,
    input  logic              ADC_SCLK_i,
    input  logic              ADC_SADDR_i,
    output logic              ADC_SDAT_o,
    input  logic              ch_wr_en_i,
    input  logic [2:0]        ch_wr_addr_i,
    input  logic [DATA_W-1:0] ch_wr_data_i,
    output logic              frame_done_o,
    output logic              frame_abort_o,
    output logic [15:0]       frame_cnt_o,
    output logic [2:0]        cur_addr_o
);

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_saddr;

    logic [SYNC_STAGES-1:0] r_saddr_sync;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [FRAME_LEN-1:0]   r_tx_sr;
    logic [FRAME_LEN-1:0]   w_tx_nx;
    logic [RX_W-1:0]        r_rx_sr;
    logic [RX_W-1:0]        w_rx_nx;
    logic [RX_W:0]          w_rx_shift;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [BIT_CNT_W-1:0]   w_bit_cnt_nx;
    logic [ADDR_W-1:0]      r_cur_addr;
    logic [ADDR_W-1:0]      w_cur_addr_nx;
    logic [ADDR_W-1:0]      r_tx_addr;
    logic [ADDR_W-1:0]      w_tx_addr_nx;
    logic [15:0]            r_frame_cnt;
    logic [15:0]            w_frame_cnt_nx;
    logic                   r_sdat;
    logic                   w_sdat_nx;
    logic                   r_done;
    logic                   w_done_nx;
    logic                   r_abort;
    logic                   w_abort_nx;

    logic [DATA_W-1:0]      r_ch_val [NUM_CH];
    logic [DATA_W-1:0]      w_ch_sel;

    sync_edge_det #(
        .STAGES   (SYNC_STAGES),
        .IDLE_VAL (1'b1)
    ) u_sclk_sync (
        .i_clk   (CLK50MHZ),
        .i_rst_n (RST_N),
        .i_async (ADC_SCLK_i),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    sync_edge_det #(
        .STAGES   (SYNC_STAGES),
        .IDLE_VAL (1'b1)
    ) u_cs_sync (
        .i_clk   (CLK50MHZ),
        .i_rst_n (RST_N),
        .i_async (ADC_CS_N_i),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // SADDR synchronizer, same depth as SCLK so data aligns with its edge
    always_ff @(posedge CLK50MHZ) begin
        if (!RST_N) begin
            r_saddr_sync <= '0;
        end else begin
            r_saddr_sync <= SYNC_STAGES'({r_saddr_sync, ADC_SADDR_i});
        end
    end

    assign w_saddr = r_saddr_sync[SYNC_STAGES-1];

    // Channel read mux; channels beyond NUM_CH read as zero
    always_comb begin
        w_ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_cur_addr == ADDR_W'(i)) begin
                w_ch_sel = r_ch_val[i];
            end
        end
    end

    assign w_rx_shift = {r_rx_sr, w_saddr};

    // Frame FSM next-state and datapath
    always_comb begin
        w_state_nx     = r_state;
        w_tx_nx        = r_tx_sr;
        w_rx_nx        = r_rx_sr;
        w_bit_cnt_nx   = r_bit_cnt;
        w_cur_addr_nx  = r_cur_addr;
        w_tx_addr_nx   = r_tx_addr;
        w_frame_cnt_nx = r_frame_cnt;
        w_done_nx      = 1'b0;
        w_abort_nx     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nx   = ST_SHIFT;
                    w_tx_nx      = {{LEAD_ZEROS{1'b0}}, w_ch_sel};
                    w_bit_cnt_nx = '0;
                    w_tx_addr_nx = r_cur_addr;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nx = ST_IDLE;
                    w_abort_nx = 1'b1;
                end else if (w_sclk_rise) begin
                    w_rx_nx      = w_rx_shift[RX_W-1:0];
                    w_bit_cnt_nx = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == BIT_CNT_W'(FRAME_LEN - 1)) begin
                        w_cur_addr_nx  = w_rx_shift[ADDR_MSB:ADDR_LSB];
                        w_done_nx      = 1'b1;
                        w_frame_cnt_nx = r_frame_cnt + 16'd1;
                        w_state_nx     = ST_DONE;
                    end
                end else if (w_sclk_fall && r_bit_cnt != '0) begin
                    // The fall preceding the first rise carries no bit:
                    // the MSB is already on the line from the load.
                    w_tx_nx = {r_tx_sr[FRAME_LEN-2:0], 1'b0};
                end
            end
            ST_DONE: begin
                if (w_cs_rise) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
        w_sdat_nx = (w_state_nx == ST_SHIFT) ? w_tx_nx[FRAME_LEN-1] : 1'b0;
    end

    // Frame FSM state and datapath registers
    always_ff @(posedge CLK50MHZ) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_tx_sr     <= '0;
            r_rx_sr     <= '0;
            r_bit_cnt   <= '0;
            r_cur_addr  <= '0;
            r_tx_addr   <= '0;
            r_frame_cnt <= '0;
            r_sdat      <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_tx_sr     <= w_tx_nx;
            r_rx_sr     <= w_rx_nx;
            r_bit_cnt   <= w_bit_cnt_nx;
            r_cur_addr  <= w_cur_addr_nx;
            r_tx_addr   <= w_tx_addr_nx;
            r_frame_cnt <= w_frame_cnt_nx;
            r_sdat      <= w_sdat_nx;
            r_done      <= w_done_nx;
            r_abort     <= w_abort_nx;
        end
    end

    // Channel value store; a host write wins over the auto increment
    always_ff @(posedge CLK50MHZ) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_ch_val[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
`ifdef ADC_AUTO_INC_EN
                if (w_done_nx && r_tx_addr == ADDR_W'(i)) begin
                    r_ch_val[i] <= r_ch_val[i] + DATA_W'(1);
                end
`endif
                if (ch_wr_en_i && ch_wr_addr_i == ADDR_W'(i)) begin
                    r_ch_val[i] <= ch_wr_data_i;
                end
            end
        end
    end

    assign ADC_SDAT_o    = r_sdat;
    assign frame_done_o  = r_done;
    assign frame_abort_o = r_abort;
    assign frame_cnt_o   = r_frame_cnt;
    assign cur_addr_o    = r_cur_addr;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Testbench for adc_spi_responder: SPI initiator, frame-level model, checks.
// Built with NUM_CH=6 so out-of-range channel writes can be observed.
module tb_adc_spi_responder;

    localparam int NCH = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n;
    logic        sclk;
    logic        saddr;
    logic        sdat;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [11:0] wr_data;
    logic        done;
    logic        abort;
    logic [15:0] fcnt;
    logic [2:0]  caddr;

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;
    int n_abort  = 0;
    bit settled  = 1'b0;

    logic [11:0] m_ch [0:7];
    logic [2:0]  m_addr;
    logic [15:0] m_cnt;

    always #10 clk = ~clk;

    adc_spi_responder #(
        .SYNC_STAGES (2),
        .NUM_CH      (NCH),
        .DATA_W      (12)
    ) dut (
        .CLK50MHZ      (clk),
        .RST_N         (rst_n),
        .ADC_CS_N_i    (cs_n),
        .ADC_SCLK_i    (sclk),
        .ADC_SADDR_i   (saddr),
        .ADC_SDAT_o    (sdat),
        .ch_wr_en_i    (wr_en),
        .ch_wr_addr_i  (wr_addr),
        .ch_wr_data_i  (wr_data),
        .frame_done_o  (done),
        .frame_abort_o (abort),
        .frame_cnt_o   (fcnt),
        .cur_addr_o    (caddr)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done)  n_done++;
        if (abort) n_abort++;
    end

    // Between frames the outputs must match the frame-level model
    always @(negedge clk) begin
        if (settled) begin
            chk("idle_cnt", 32'(fcnt), 32'(m_cnt));
            chk("idle_addr", 32'(caddr), 32'(m_addr));
            chk("idle_sdat", 32'(sdat), 0);
            chk("idle_pulses", 32'({done, abort}), 0);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_ch[i] = '0;
        m_addr = '0;
        m_cnt  = '0;
    endtask

    task automatic wr_ch(input logic [2:0] a, input logic [11:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (int'(a) < NCH) m_ch[a] = d;
    endtask

    task automatic frame(input logic [15:0] din, input int nbits,
                         input int wr_at, input logic [2:0] wa,
                         input logic [11:0] wd, input int rst_at,
                         output logic [15:0] dout);
        logic [15:0] exp;
        logic [2:0]  tx_ch;
        int d0, a0;
        bit full;
        full    = (nbits == 16);
        settled = 1'b0;
        tx_ch   = m_addr;
        exp     = (int'(tx_ch) < NCH) ? {4'h0, m_ch[tx_ch]} : 16'h0;
        d0      = n_done;
        a0      = n_abort;
        dout    = '0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                chk("rst_sdat", 32'(sdat), 0);
                chk("rst_cnt", 32'(fcnt), 0);
                chk("rst_addr", 32'(caddr), 0);
                chk("rst_pulses", 32'({done, abort}), 0);
                cs_n = 1'b1; sclk = 1'b1; saddr = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (8) @(negedge clk);
                chk("rst_no_abort", 32'(n_abort - a0), 0);
                model_reset();
                settled = 1'b1;
                return;
            end
            sclk  = 1'b0;
            saddr = din[15-i];
            if (i == wr_at) begin
                wr_en = 1'b1; wr_addr = wa; wr_data = wd;
                @(negedge clk);
                wr_en = 1'b0;
                if (int'(wa) < NCH) m_ch[wa] = wd;
                repeat (5) @(negedge clk);
            end else begin
                repeat (6) @(negedge clk);
            end
            dout[15-i] = sdat;
            chk("sdat_bit", 32'(sdat), 32'(exp[15-i]));
            sclk = 1'b1;
            repeat (6) @(negedge clk);
        end
        if (full) begin
            chk("done_sdat", 32'(sdat), 0);
            sclk = 1'b0;
            repeat (6) @(negedge clk);
            chk("done_sdat_fall", 32'(sdat), 0);
            sclk = 1'b1;
            repeat (6) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("done_pulses", 32'(n_done - d0), full ? 1 : 0);
        chk("abort_pulses", 32'(n_abort - a0), full ? 0 : 1);
        if (full) begin
`ifdef ADC_AUTO_INC_EN
            if (int'(tx_ch) < NCH) m_ch[tx_ch] = m_ch[tx_ch] + 12'd1;
`endif
            m_addr = din[13:11];
            m_cnt  = m_cnt + 16'd1;
        end
        settled = 1'b1;
    endtask

    task automatic run(input logic [15:0] din, output logic [15:0] dout);
        frame(din, 16, -1, 3'd0, 12'd0, -1, dout);
    endtask

    initial begin
        logic [15:0] d;
        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b1; saddr = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        repeat (4) @(negedge clk);
        chk("reset_out", 32'({sdat, done, abort, caddr, fcnt}), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        settled = 1'b1;

        wr_ch(3'd0, 12'hABC);
        run(16'h0000, d);
        chk("ch0_data", 32'(d), 32'h0ABC);
        chk("ch0_cnt", 32'(fcnt), 1);

        wr_ch(3'd5, 12'h123);
        run(16'h2800, d);
        run(16'h2800, d);
        chk("ch5_data", 32'(d), 32'h0123);
        chk("ch5_addr", 32'(caddr), 5);

        frame(16'h0000, 7, -1, 3'd0, 12'd0, -1, d);
        chk("abort_cnt", 32'(fcnt), 3);
        chk("abort_addr", 32'(caddr), 5);
        run(16'h0000, d);
`ifdef ADC_AUTO_INC_EN
        chk("after_abort", 32'(d), 32'h0124);
`else
        chk("after_abort", 32'(d), 32'h0123);
`endif

        wr_ch(3'd0, 12'h111);
        frame(16'h0000, 16, 5, 3'd0, 12'h555, -1, d);
        chk("midwr_cur", 32'(d), 32'h0111);
        run(16'h0000, d);
`ifdef ADC_AUTO_INC_EN
        chk("midwr_next", 32'(d), 32'h0556);
`else
        chk("midwr_next", 32'(d), 32'h0555);
`endif

        wr_ch(3'd0, 12'hFFF);
        run(16'h0000, d);
        chk("wrap_first", 32'(d), 32'h0FFF);
        run(16'h0000, d);
`ifdef ADC_AUTO_INC_EN
        chk("wrap_second", 32'(d), 32'h0000);
`else
        chk("wrap_second", 32'(d), 32'h0FFF);
`endif

        wr_ch(3'd6, 12'h777);
        run(16'h3000, d);
        run(16'h0000, d);
        chk("oob_write", 32'(d), 32'h0000);

        wr_ch(3'd3, 12'h3C3);
        run(16'h1800, d);
        frame(16'h0000, 16, -1, 3'd0, 12'd0, 9, d);
        run(16'h1800, d);
        chk("post_rst_data", 32'(d), 32'h0000);
        chk("post_rst_cnt", 32'(fcnt), 1);
        chk("post_rst_addr", 32'(caddr), 3);

        settled = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
